// File: rtl/tcdm_stall_memory_if.sv
// hwpe_stream_intf_tcdm: TCDM load/store handshake between a streamer master
// and a memory slave; gnt is the request acknowledge, r_valid the response strobe.
interface hwpe_stream_intf_tcdm #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [31:0]             add;
    logic                    wen;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_stall_memory.sv
// tcdm_stall_memory: multi-port TCDM responder with LFSR-driven random stalls,
// one-cycle read latency and saturating grant/stall counters.
module tcdm_stall_memory #(
    parameter int unsigned MP           = 1,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_SIZE  = 128,
    parameter logic [31:0] BASE_ADDR    = '0,
    parameter int unsigned STALL_THRESH = 26,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                enable_i,
    hwpe_stream_intf_tcdm.slave tcdm [MP],
    output logic [31:0]         nb_gnt_o,
    output logic [31:0]         nb_stall_o
);
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned NW = MEMORY_SIZE / NB;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned OW = $clog2(NB);
    localparam logic [8:0]  THRESH = 9'(STALL_THRESH);

    logic [MP-1:0]                 req, wen, gnt, stall, r_valid_q, r_valid_d;
    logic [MP-1:0][NB-1:0]         be;
    logic [MP-1:0][DATA_WIDTH-1:0] wdata, r_data_q, r_data_d;
    logic [MP-1:0][IW-1:0]         idx;
    logic [MP-1:0][15:0]           lfsr_q, lfsr_d;
    logic [NW-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [31:0]                   nb_gnt_q, nb_gnt_d, nb_stall_q, nb_stall_d;
    logic [32:0]                   gnt_sum, stall_sum;

    for (genvar p = 0; p < MP; p++) begin : g_port
        assign req[p]         = tcdm[p].req;
        assign wen[p]         = tcdm[p].wen;
        assign be[p]          = tcdm[p].be;
        assign wdata[p]       = tcdm[p].data;
        assign idx[p]         = IW'((tcdm[p].add - BASE_ADDR) >> OW);
        assign stall[p]       = {1'b0, lfsr_q[p][7:0]} < THRESH;
        // Reset gating keeps gnt low even though seeds may not stall.
        assign gnt[p]         = rst_ni & req[p] & enable_i & ~stall[p];
        assign tcdm[p].gnt     = gnt[p];
        assign tcdm[p].r_valid = r_valid_q[p];
        assign tcdm[p].r_data  = r_data_q[p];
    end

    always_comb begin
        mem_d     = mem_q;
        gnt_sum   = {1'b0, nb_gnt_q};
        stall_sum = {1'b0, nb_stall_q};
        for (int p = 0; p < MP; p++) begin
            gnt_sum      = gnt_sum + 33'(gnt[p]);
            stall_sum    = stall_sum + 33'(req[p] & ~gnt[p]);
            lfsr_d[p]    = clear_i ? LFSR_SEED + 16'(p) :
                           enable_i ? {lfsr_q[p][0] ^ lfsr_q[p][2] ^ lfsr_q[p][3] ^ lfsr_q[p][5], lfsr_q[p][15:1]} :
                           lfsr_q[p];
            r_valid_d[p] = ~clear_i & gnt[p];
            r_data_d[p]  = clear_i ? '0 : gnt[p] ? (wen[p] ? mem_q[idx[p]] : '0) : r_data_q[p];
            // Later (higher) ports overwrite earlier ones byte by byte.
            for (int b = 0; b < NB; b++)
                if (gnt[p] && !wen[p] && be[p][b])
                    mem_d[idx[p]][8*b +: 8] = wdata[p][8*b +: 8];
        end
        nb_gnt_d   = clear_i ? '0 : gnt_sum[32] ? '1 : gnt_sum[31:0];
        nb_stall_d = clear_i ? '0 : stall_sum[32] ? '1 : stall_sum[31:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NW; i++)
                mem_q[i] <= DATA_WIDTH'(i * NB);
            for (int p = 0; p < MP; p++)
                lfsr_q[p] <= LFSR_SEED + 16'(p);
            r_valid_q  <= '0;
            r_data_q   <= '0;
            nb_gnt_q   <= '0;
            nb_stall_q <= '0;
        end else begin
            mem_q      <= mem_d;
            lfsr_q     <= lfsr_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            nb_gnt_q   <= nb_gnt_d;
            nb_stall_q <= nb_stall_d;
        end
    end

    assign nb_gnt_o   = nb_gnt_q;
    assign nb_stall_o = nb_stall_q;
endmodule

// File: tb/tb_tcdm_stall_memory.sv
// tb_tcdm_stall_memory: directed checks on a stall-free two-port instance and
// randomized checks of a default-stall single-port instance against a model.
module tb_tcdm_stall_memory;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_a = 1'b0, en_a = 1'b1, clr_b = 1'b0, en_b = 1'b1;
    logic [31:0] ga, sa, gb, sb;
    int total = 0, bad = 0;
    int exp_ga = 0, exp_sa = 0;

    logic [1:0]       a_req, a_wen, a_gnt, a_rv;
    logic [1:0][31:0] a_add, a_data, a_rd;
    logic [1:0][3:0]  a_be;
    logic             b_req, b_wen, b_gnt, b_rv;
    logic [31:0]      b_add, b_data, b_rd;
    logic [3:0]       b_be;

    always #5 clk = ~clk;

    hwpe_stream_intf_tcdm #(.DATA_WIDTH(32)) a_if [2] ();
    hwpe_stream_intf_tcdm #(.DATA_WIDTH(32)) b_if [1] ();

    for (genvar g = 0; g < 2; g++) begin : g_a
        assign a_if[g].req  = a_req[g];
        assign a_if[g].wen  = a_wen[g];
        assign a_if[g].add  = a_add[g];
        assign a_if[g].be   = a_be[g];
        assign a_if[g].data = a_data[g];
        assign a_gnt[g]     = a_if[g].gnt;
        assign a_rv[g]      = a_if[g].r_valid;
        assign a_rd[g]      = a_if[g].r_data;
    end
    assign b_if[0].req  = b_req;
    assign b_if[0].wen  = b_wen;
    assign b_if[0].add  = b_add;
    assign b_if[0].be   = b_be;
    assign b_if[0].data = b_data;
    assign b_gnt        = b_if[0].gnt;
    assign b_rv         = b_if[0].r_valid;
    assign b_rd         = b_if[0].r_data;

    tcdm_stall_memory #(.MP(2), .STALL_THRESH(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr_a), .enable_i(en_a),
        .tcdm(a_if), .nb_gnt_o(ga), .nb_stall_o(sa)
    );
    tcdm_stall_memory #(.MP(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr_b), .enable_i(en_b),
        .tcdm(b_if), .nb_gnt_o(gb), .nb_stall_o(sb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int p, input logic r, input logic w, input logic [31:0] ad,
                         input logic [3:0] b, input logic [31:0] d);
        a_req[p] = r; a_wen[p] = w; a_add[p] = ad; a_be[p] = b; a_data[p] = d;
    endtask

    task automatic chk_gnt_a(input int p, input logic e, input string nm);
        #1;
        total++;
        if (a_gnt[p] !== e) begin
            bad++;
            $display("FAIL %s gnt got=%b want=%b", nm, a_gnt[p], e);
        end
    endtask

    task automatic chk_resp_a(input int p, input logic v, input logic [31:0] d, input string nm);
        total++;
        if (a_rv[p] !== v || a_rd[p] !== d) begin
            bad++;
            $display("FAIL %s r_valid/r_data got=%b/%h want=%b/%h", nm, a_rv[p], a_rd[p], v, d);
        end
    endtask

    task automatic chk_cnt_a(input string nm);
        total++;
        if (ga !== 32'(exp_ga) || sa !== 32'(exp_sa)) begin
            bad++;
            $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", nm, ga, sa, exp_ga, exp_sa);
        end
    endtask

    task automatic test_reset();
        set_a(0, 1'b1, 1'b1, 32'd0, 4'hf, 32'd0);
        chk_gnt_a(0, 1'b0, "reset_gnt");
        chk_resp_a(0, 1'b0, 32'd0, "reset_resp");
        chk_cnt_a("reset_cnt");
        total++;
        if (gb !== 32'd0 || sb !== 32'd0 || b_rv !== 1'b0 || b_gnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_b got gnt=%0d stall=%0d rv=%b g=%b want 0", gb, sb, b_rv, b_gnt);
        end
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_seq();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) chk_resp_a(0, 1'b1, 32'(4 * (i - 1)), "read_seq");
            if (i < 3) begin
                set_a(0, 1'b1, 1'b1, 32'(4 * i), 4'hf, 32'd0);
                chk_gnt_a(0, 1'b1, "read_seq");
                exp_ga++;
            end else set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
            step();
        end
        chk_cnt_a("read_seq_cnt");
    endtask

    task automatic test_write_be();
        set_a(0, 1'b1, 1'b0, 32'd12, 4'b0101, 32'hAABBCCDD);
        chk_gnt_a(0, 1'b1, "write_be");
        exp_ga++;
        step();
        chk_resp_a(0, 1'b1, 32'd0, "write_resp");
        set_a(0, 1'b1, 1'b1, 32'd12, 4'hf, 32'd0);
        exp_ga++;
        step();
        chk_resp_a(0, 1'b1, 32'h00BB00DD, "write_be_read");
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        step();
        chk_resp_a(0, 1'b0, 32'h00BB00DD, "rdata_hold");
    endtask

    task automatic test_wrap();
        set_a(0, 1'b1, 1'b1, 32'd128, 4'hf, 32'd0);
        exp_ga++;
        step();
        chk_resp_a(0, 1'b1, 32'd0, "wrap128");
        set_a(0, 1'b1, 1'b1, 32'd132, 4'hf, 32'd0);
        exp_ga++;
        step();
        chk_resp_a(0, 1'b1, 32'd4, "wrap132");
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        step();
    endtask

    task automatic test_same_word();
        set_a(0, 1'b1, 1'b0, 32'd20, 4'hf, 32'h11111111);
        set_a(1, 1'b1, 1'b0, 32'd20, 4'hf, 32'h22222222);
        chk_gnt_a(1, 1'b1, "same_word_p1");
        exp_ga += 2;
        step();
        set_a(1, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        set_a(0, 1'b1, 1'b1, 32'd20, 4'hf, 32'd0);
        exp_ga++;
        step();
        chk_resp_a(0, 1'b1, 32'h22222222, "same_word");
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        step();
        chk_cnt_a("same_word_cnt");
    endtask

    task automatic test_enable();
        set_a(0, 1'b1, 1'b1, 32'd8, 4'hf, 32'd0);
        exp_ga++;
        step();
        en_a = 1'b0;
        chk_gnt_a(0, 1'b0, "enable_off");
        chk_resp_a(0, 1'b1, 32'd8, "enable_inflight");
        exp_sa++;
        step();
        chk_resp_a(0, 1'b0, 32'd8, "enable_noresp");
        chk_cnt_a("enable_cnt");
        en_a = 1'b1;
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        step();
    endtask

    task automatic test_clear();
        clr_a = 1'b1;
        set_a(0, 1'b1, 1'b0, 32'd24, 4'hf, 32'hCAFEF00D);
        chk_gnt_a(0, 1'b1, "clear_gnt");
        step();
        clr_a = 1'b0;
        exp_ga = 0;
        exp_sa = 0;
        chk_resp_a(0, 1'b0, 32'd0, "clear_resp");
        chk_cnt_a("clear_cnt");
        set_a(0, 1'b1, 1'b1, 32'd24, 4'hf, 32'd0);
        exp_ga++;
        step();
        chk_resp_a(0, 1'b1, 32'hCAFEF00D, "clear_keeps_mem");
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        step();
        chk_cnt_a("clear_cnt2");
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic test_random();
        logic [31:0] mem [32];
        logic [15:0] l;
        logic        exp_rv, eg;
        logic [31:0] exp_rd;
        int          mg, ms, mism;
        bit          gseq [1000];
        for (int i = 0; i < 32; i++) mem[i] = 32'(4 * i);
        for (int ph = 0; ph < 2; ph++) begin
            b_req = 1'b0;
            clr_b = 1'b1;
            step();
            clr_b = 1'b0;
            l = 16'hACE1; mg = 0; ms = 0; mism = 0; exp_rv = 1'b0; exp_rd = '0;
            for (int n = 0; n < 1000; n++) begin
                int w;
                b_req = 1'b1;
                b_wen = 1'($urandom_range(0, 1));
                b_add = $urandom;
                b_be  = 4'($urandom);
                b_data = $urandom;
                #1;
                eg = l[7:0] >= 8'd26;
                total++;
                if (b_gnt !== eg) begin
                    bad++;
                    $display("FAIL rand_gnt n=%0d got=%b want=%b", n, b_gnt, eg);
                end
                if (ph == 0) gseq[n] = eg;
                else if (gseq[n] != eg) mism++;
                w = int'(b_add >> 2) % 32;
                if (eg) begin
                    mg++;
                    exp_rd = b_wen ? mem[w] : 32'd0;
                    if (!b_wen)
                        for (int k = 0; k < 4; k++)
                            if (b_be[k]) mem[w][8*k +: 8] = b_data[8*k +: 8];
                end else ms++;
                exp_rv = eg;
                l = lfsr_next(l);
                step();
                total++;
                if (b_rv !== exp_rv || b_rd !== exp_rd) begin
                    bad++;
                    $display("FAIL rand_resp n=%0d got=%b/%h want=%b/%h", n, b_rv, b_rd, exp_rv, exp_rd);
                end
            end
            b_req = 1'b0;
            total++;
            if (gb !== 32'(mg) || sb !== 32'(ms) || mg + ms != 1000) begin
                bad++;
                $display("FAIL rand_cnt got=%0d/%0d want=%0d/%0d", gb, sb, mg, ms);
            end
            total++;
            if (ms < 70 || ms > 140) begin
                bad++;
                $display("FAIL rand_ratio stalls=%0d want 70..140", ms);
            end
            if (ph == 1) begin
                total++;
                if (mism != 0) begin
                    bad++;
                    $display("FAIL rand_repeat mismatches=%0d want 0", mism);
                end
            end
        end
        step();
    endtask

    task automatic test_async_reset();
        set_a(0, 1'b1, 1'b0, 32'd12, 4'hf, 32'hDEAD0000);
        step();
        set_a(0, 1'b1, 1'b1, 32'd12, 4'hf, 32'd0);
        chk_gnt_a(0, 1'b1, "areset_gnt");
        step();
        chk_resp_a(0, 1'b1, 32'hDEAD0000, "areset_pre");
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        set_a(0, 1'b1, 1'b1, 32'd12, 4'hf, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        exp_ga = 0;
        exp_sa = 0;
        chk_resp_a(0, 1'b0, 32'd0, "areset_drop");
        chk_gnt_a(0, 1'b0, "areset_gnt_low");
        chk_cnt_a("areset_cnt");
        step();
        chk_resp_a(0, 1'b0, 32'd0, "areset_hold");
        rst_n = 1'b1;
        exp_ga++;
        step();
        chk_resp_a(0, 1'b1, 32'd12, "areset_reinit");
        set_a(0, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        step();
    endtask

    initial begin
        for (int p = 0; p < 2; p++) set_a(p, 1'b0, 1'b1, 32'd0, 4'hf, 32'd0);
        b_req = 1'b0; b_wen = 1'b1; b_add = '0; b_be = '0; b_data = '0;
        step();
        test_reset();
        test_read_seq();
        test_write_be();
        test_wrap();
        test_same_word();
        test_enable();
        test_clear();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
